// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared constants, note table and FSM states for the voice scheduler
package voice_pkg;

  localparam int NUM_KEYS = 13;

  localparam logic [31:0] NOTE_TABLE [NUM_KEYS] = '{
    32'd191113, 32'd180387, 32'd170262, 32'd160706, 32'd151686,
    32'd143173, 32'd135137, 32'd127553, 32'd120394, 32'd113636,
    32'd107258, 32'd101238, 32'd95556
  };

  typedef enum logic [1:0] {SCAN, DIV_WAIT, RESCALE, RESCALE_WAIT} sched_state_t;

  // Out-of-range key indices read as 0 rather than indexing past the table.
  function automatic logic [31:0] note_lookup(input logic [3:0] key);
    logic [31:0] note;
    note = '0;
    if (key < 4'(NUM_KEYS)) note = NOTE_TABLE[key];
    return note;
  endfunction

  function automatic logic [2:0] scale_eff(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

endpackage

// File: rtl/note_divider.sv
// rtl/note_divider.sv - restoring divider, 1 load cycle plus one quotient bit per cycle
module note_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W) + 1;

  logic         busy_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] dvs_q;
  logic [CW-1:0] iter_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q <= 1'b1;
          rem_q  <= '0;
          quo_q  <= dividend;
          dvs_q  <= divisor;
          iter_q <= '0;
        end
      end else begin
        // Quotient bits shift in from the bottom as dividend bits shift out the top.
        if (!diff[W]) begin
          rem_q <= diff[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        iter_q <= iter_q + 1'b1;
        if (iter_q == CW'(W - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - scans keys, allocates tone voices and computes half periods
module voice_scheduler
  import voice_pkg::*;
#(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_KEYS-1:0]           KEYBOARD,
  input  logic [2:0]                    scale,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [NUM_VOICES*4-1:0]       voice_key,
  output logic [NUM_VOICES*CNT_W-1:0]   voice_half_period,
  output logic                          voice_update,
  output logic                          alloc_overflow
);

  localparam int VI_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  sched_state_t          state_q, state_n;
  logic [3:0]            ptr_q, ptr_n;
  logic [VI_W-1:0]       vidx_q, vidx_n;
  logic [2:0]            scale_lat_q, scale_lat_n;
  logic                  skip_q, skip_n;
  logic                  overflow_q, overflow_n;
  logic                  upd_q, upd_n;
  logic                  div_start_q, div_start_n;
  logic [NUM_VOICES-1:0] active_q, active_n;
  logic [3:0]            key_q [NUM_VOICES];
  logic [3:0]            key_n [NUM_VOICES];
  logic [CNT_W-1:0]      hp_q  [NUM_VOICES];
  logic [CNT_W-1:0]      hp_n  [NUM_VOICES];

  logic                  pressed;
  logic                  owned;
  logic [VI_W-1:0]       owner;
  logic                  free_found;
  logic [VI_W-1:0]       free_idx;
  logic                  advance;
  logic                  skip_now;
  logic [2:0]            scale_now;

  logic                  div_done;
  logic [31:0]           div_quotient;
  logic [31:0]           div_dividend;
  logic [31:0]           div_divisor;

  assign div_dividend = (state_q == DIV_WAIT) ? note_lookup(ptr_q) : note_lookup(key_q[vidx_q]);
  assign div_divisor  = {28'd0, scale_lat_q, 1'b0};
  assign scale_now    = scale_eff(scale);
  assign pressed      = KEYBOARD[ptr_q];

  note_divider #(.W(32)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start_q),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    owned      = 1'b0;
    owner      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v] && key_q[v] == ptr_q) begin
        owned = 1'b1;
        owner = VI_W'(v);
      end
      if (!active_q[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VI_W'(v);
      end
    end
  end

  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    vidx_n      = vidx_q;
    scale_lat_n = scale_lat_q;
    skip_n      = skip_q;
    overflow_n  = overflow_q;
    upd_n       = 1'b0;
    div_start_n = 1'b0;
    active_n    = active_q;
    key_n       = key_q;
    hp_n        = hp_q;
    advance     = 1'b0;
    skip_now    = 1'b0;

    case (state_q)
      SCAN: begin
        if (pressed && !owned) begin
          if (free_found) begin
            vidx_n      = free_idx;
            div_start_n = 1'b1;
            state_n     = DIV_WAIT;
          end else begin
            skip_now = 1'b1;
            advance  = 1'b1;
          end
        end else if (!pressed && owned) begin
          active_n[owner] = 1'b0;
          hp_n[owner]     = '0;
          upd_n           = 1'b1;
          advance         = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (div_done) begin
          key_n[vidx_q]    = ptr_q;
          hp_n[vidx_q]     = CNT_W'(div_quotient);
          active_n[vidx_q] = 1'b1;
          upd_n            = 1'b1;
          state_n          = SCAN;
          advance          = 1'b1;
        end
      end
      RESCALE: begin
        if (active_q[vidx_q]) begin
          div_start_n = 1'b1;
          state_n     = RESCALE_WAIT;
        end else if (vidx_q == VI_W'(NUM_VOICES - 1)) begin
          state_n = SCAN;
          ptr_n   = '0;
        end else begin
          vidx_n = vidx_q + 1'b1;
        end
      end
      RESCALE_WAIT: begin
        if (div_done) begin
          hp_n[vidx_q] = CNT_W'(div_quotient);
          upd_n        = 1'b1;
          if (vidx_q == VI_W'(NUM_VOICES - 1)) begin
            state_n = SCAN;
            ptr_n   = '0;
          end else begin
            vidx_n  = vidx_q + 1'b1;
            state_n = RESCALE;
          end
        end
      end
      default: state_n = SCAN;
    endcase

    // Pass boundary: publish overflow from the finished pass and check for a scale change.
    if (advance) begin
      if (ptr_q == 4'(NUM_KEYS - 1)) begin
        ptr_n      = '0;
        overflow_n = skip_q | skip_now;
        skip_n     = 1'b0;
        if (scale_now != scale_lat_q) begin
          scale_lat_n = scale_now;
          vidx_n      = '0;
          state_n     = RESCALE;
        end
      end else begin
        ptr_n  = ptr_q + 1'b1;
        skip_n = skip_q | skip_now;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      vidx_q      <= '0;
      scale_lat_q <= 3'd1;
      skip_q      <= 1'b0;
      overflow_q  <= 1'b0;
      upd_q       <= 1'b0;
      div_start_q <= 1'b0;
      active_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        hp_q[v]  <= '0;
      end
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      vidx_q      <= vidx_n;
      scale_lat_q <= scale_lat_n;
      skip_q      <= skip_n;
      overflow_q  <= overflow_n;
      upd_q       <= upd_n;
      div_start_q <= div_start_n;
      active_q    <= active_n;
      key_q       <= key_n;
      hp_q        <= hp_n;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*4 +: 4]                 = key_q[v];
      voice_half_period[v*CNT_W +: CNT_W] = hp_q[v];
    end
  end

  assign voice_active   = active_q;
  assign voice_update   = upd_q;
  assign alloc_overflow = overflow_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
`timescale 1ns/1ps
module tb_voice_scheduler;

  logic        clk;
  logic        reset_n;
  logic [12:0] KEYBOARD;
  logic [2:0]  scale;
  logic [3:0]  voice_active;
  logic [15:0] voice_key;
  logic [127:0] voice_half_period;
  logic        voice_update;
  logic        alloc_overflow;

  int n_checks;
  int n_errors;

  voice_scheduler #(.NUM_KEYS(13), .NUM_VOICES(4), .CNT_W(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .KEYBOARD          (KEYBOARD),
    .scale             (scale),
    .voice_active      (voice_active),
    .voice_key         (voice_key),
    .voice_half_period (voice_half_period),
    .voice_update      (voice_update),
    .alloc_overflow    (alloc_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] hp_of(input int v);
    return voice_half_period[v*32 +: 32];
  endfunction

  function automatic logic [3:0] key_of(input int v);
    return voice_key[v*4 +: 4];
  endfunction

  task automatic do_reset(input logic [12:0] keys, input logic [2:0] s);
    reset_n  = 1'b0;
    KEYBOARD = keys;
    scale    = s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_updates(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (voice_update) cnt++;
    end
  endtask

  int lat;
  int ups;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    KEYBOARD = '0;
    scale    = 3'd1;
    #12;
    check("rst_active",   voice_active, 0);
    check("rst_key",      voice_key, 0);
    check("rst_hp",       voice_half_period, 0);
    check("rst_update",   voice_update, 0);
    check("rst_overflow", alloc_overflow, 0);

    // Key 0 at scale 1: 191113/2, and exact allocation latency from the first scan.
    do_reset(13'h0001, 3'd1);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (voice_active[0] && lat == 0) lat = i;
    end
    check("alloc_latency", lat, 35);
    check("t1_active", voice_active, 4'b0001);
    check("t1_key0",   key_of(0), 0);
    check("t1_hp0",    hp_of(0), 95556);
    check("t1_hp1",    hp_of(1), 0);
    check("t1_hp3",    hp_of(3), 0);

    // Scale 2, key 9: 113636/4; then release gives a single update pulse.
    KEYBOARD = '0;
    wait_cycles(30);
    check("t2_released", voice_active, 0);
    scale = 3'd2;
    wait_cycles(80);
    KEYBOARD = 13'h0200;
    wait_cycles(80);
    check("t2_active", voice_active, 4'b0001);
    check("t2_key0",   key_of(0), 9);
    check("t2_hp0",    hp_of(0), 28409);
    KEYBOARD = '0;
    count_updates(30, ups);
    check("t2_rel_updates", ups, 1);
    check("t2_rel_active",  voice_active, 0);
    check("t2_rel_hp0",     hp_of(0), 0);

    // Five keys, four voices at scale 3; key 12 is left over.
    do_reset(13'h10A9, 3'd3);
    wait_cycles(400);
    check("t3_active", voice_active, 4'hF);
    check("t3_key0", key_of(0), 0);
    check("t3_key1", key_of(1), 3);
    check("t3_key2", key_of(2), 5);
    check("t3_key3", key_of(3), 7);
    check("t3_hp0",  hp_of(0), 31852);
    check("t3_hp1",  hp_of(1), 26784);
    check("t3_hp2",  hp_of(2), 23862);
    check("t3_hp3",  hp_of(3), 21258);
    check("t3_overflow", alloc_overflow, 1);
    KEYBOARD = 13'h10A1;
    wait_cycles(200);
    check("t3_realloc_key1", key_of(1), 12);
    check("t3_realloc_hp1",  hp_of(1), 15926);
    check("t3_realloc_act",  voice_active, 4'hF);
    check("t3_no_overflow",  alloc_overflow, 0);

    // Held keys 0 and 12 rescaled from 1 to 2.
    do_reset(13'h1001, 3'd1);
    wait_cycles(150);
    check("t4_hp0_s1", hp_of(0), 95556);
    check("t4_hp1_s1", hp_of(1), 47778);
    scale = 3'd2;
    wait_cycles(200);
    check("t4_hp0_s2", hp_of(0), 47778);
    check("t4_hp1_s2", hp_of(1), 23889);
    check("t4_key1",   key_of(1), 12);

    // Scale 0 behaves as scale 1.
    do_reset(13'h1000, 3'd0);
    wait_cycles(100);
    check("t5_key0",   key_of(0), 12);
    check("t5_hp0",    hp_of(0), 47778);
    check("t5_active", voice_active, 4'b0001);

    // Reset asserted while key 5 is being divided.
    do_reset(13'h0021, 3'd1);
    repeat (50) @(posedge clk);
    #2;
    check("t6_pre_active", voice_active, 4'b0001);
    reset_n = 1'b0;
    #1;
    check("t6_async_active", voice_active, 0);
    check("t6_async_key",    voice_key, 0);
    check("t6_async_hp",     voice_half_period, 0);
    check("t6_async_update", voice_update, 0);
    check("t6_async_ovf",    alloc_overflow, 0);
    KEYBOARD = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_updates(60, ups);
    check("t6_post_updates", ups, 0);
    check("t6_post_active",  voice_active, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
